// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal transmit FIFO.
// Queued words are sent LSB first as frames of
//   start(0), DATA_BITS data, optional parity, STOP_BITS stop(1).
// Frames leave back-to-back while the FIFO holds data.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous reset, active-high
//   i_TX_DV      write strobe, one entry pushed per cycle while high
//   i_TX_Byte    data word to queue
//   o_Full       FIFO holds FIFO_DEPTH entries
//   o_Empty      FIFO holds no entries
//   o_Count      current FIFO occupancy
//   o_Overflow   one-cycle pulse after a write was dropped (FIFO full)
//   TX           registered serial line, idle high
//   o_TX_Active  high while a frame is on the line
//   o_TX_Done    one-cycle pulse at the end of each frame's last stop bit
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_TX_DV,
  input  logic [DATA_BITS-1:0]          i_TX_Byte,
  output logic                          o_Full,
  output logic                          o_Empty,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_Overflow,
  output logic                          TX,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = $clog2(STOP_BITS * CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]   DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]      count_q, count_d;
  logic                 ovf_q;

  // Transmitter state
  state_t               state_q;
  logic [CW-1:0]        clk_cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 parity_q;
  logic                 tx_q;
  logic                 active_q;
  logic                 done_q;

  logic                 push;
  logic                 pop;
  logic                 last_stop;
  logic [DATA_BITS-1:0] head;
  logic                 head_parity;

  assign o_Count     = count_q;
  assign o_Full      = (count_q == DEPTH_CNT);
  assign o_Empty     = (count_q == '0);
  assign o_Overflow  = ovf_q;
  assign TX          = tx_q;
  assign o_TX_Active = active_q;
  assign o_TX_Done   = done_q;

  assign head        = mem_q[rd_ptr_q];
  // Odd mode: parity set when the data holds an even number of ones.
  assign head_parity = (PARITY == 1) ? ~(^head) : (^head);

  // A pop happens on any edge where the transmitter can take a new word:
  // while idle, or on the final cycle of the last stop bit.
  assign last_stop = (state_q == S_STOP) && (clk_cnt_q == STOP_LAST);
  assign pop       = (count_q != '0) && ((state_q == S_IDLE) || last_stop);
  // Full blocks writes even if a pop frees a slot on the same edge.
  assign push      = i_TX_DV && !o_Full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= i_TX_Byte;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= i_TX_DV && o_Full;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q     <= 1'b1;
          active_q <= 1'b0;
          if (pop) begin
            shift_q   <= head;
            parity_q  <= head_parity;
            tx_q      <= 1'b0;
            active_q  <= 1'b1;
            clk_cnt_q <= '0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == DATA_LAST) begin
              if (PARITY != 0) begin
                tx_q    <= parity_q;
                state_q <= S_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              // Shift right so the next bit to send always sits at index 1.
              bit_idx_q <= bit_idx_q + BW'(1);
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            tx_q      <= 1'b1;
            state_q   <= S_STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (last_stop) begin
            done_q    <= 1'b1;
            clk_cnt_q <= '0;
            if (pop) begin
              // Back-to-back: next start bit begins with no idle cycle.
              shift_q  <= head;
              parity_q <= head_parity;
              tx_q     <= 1'b0;
              state_q  <= S_START;
            end else begin
              tx_q     <= 1'b1;
              active_q <= 1'b0;
              state_q  <= S_IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        default: begin
          tx_q     <= 1'b1;
          active_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench for uart_tx_fifo.
// Three instances share clock and reset:
//   A: 8N1, B: 7 data bits / even parity / 2 stop bits, C: 8 data bits / odd parity / 1 stop bit.
// All use CLKS_PER_BIT = 4 and FIFO_DEPTH = 4. One instance is driven and observed at a time.
// The reference model holds a queue of accepted words plus the frame in
// flight as a bit list and a time offset within it.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int HIST  = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       dv;
  logic [7:0] din;

  always #5 clk = ~clk;

  logic       dv_a, dv_b, dv_c;
  logic       full_a, full_b, full_c;
  logic       empty_a, empty_b, empty_c;
  logic [2:0] count_a, count_b, count_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic       tx_a, tx_b, tx_c;
  logic       act_a, act_b, act_c;
  logic       done_a, done_b, done_c;

  assign dv_a = dv && (sel == 2'd0);
  assign dv_b = dv && (sel == 2'd1);
  assign dv_c = dv && (sel == 2'd2);

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_a (
    .CLK(clk), .RST(rst), .i_TX_DV(dv_a), .i_TX_Byte(din[7:0]),
    .o_Full(full_a), .o_Empty(empty_a), .o_Count(count_a), .o_Overflow(ovf_a),
    .TX(tx_a), .o_TX_Active(act_a), .o_TX_Done(done_a));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_b (
    .CLK(clk), .RST(rst), .i_TX_DV(dv_b), .i_TX_Byte(din[6:0]),
    .o_Full(full_b), .o_Empty(empty_b), .o_Count(count_b), .o_Overflow(ovf_b),
    .TX(tx_b), .o_TX_Active(act_b), .o_TX_Done(done_b));

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_c (
    .CLK(clk), .RST(rst), .i_TX_DV(dv_c), .i_TX_Byte(din[7:0]),
    .o_Full(full_c), .o_Empty(empty_c), .o_Count(count_c), .o_Overflow(ovf_c),
    .TX(tx_c), .o_TX_Active(act_c), .o_TX_Done(done_c));

  // Outputs of the instance under test
  logic       full_o, empty_o, ovf_o, tx_o, act_o, done_o;
  logic [2:0] count_o;

  always_comb begin
    full_o = full_a; empty_o = empty_a; count_o = count_a; ovf_o = ovf_a;
    tx_o = tx_a; act_o = act_a; done_o = done_a;
    case (sel)
      2'd1: begin
        full_o = full_b; empty_o = empty_b; count_o = count_b; ovf_o = ovf_b;
        tx_o = tx_b; act_o = act_b; done_o = done_b;
      end
      2'd2: begin
        full_o = full_c; empty_o = empty_c; count_o = count_c; ovf_o = ovf_c;
        tx_o = tx_c; act_o = act_c; done_o = done_c;
      end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Per-instance frame format
  int cfg_db   [3] = '{8, 7, 8};
  int cfg_par  [3] = '{0, 2, 1};
  int cfg_stop [3] = '{1, 2, 1};

  // Reference model
  int unsigned mq[$];
  bit          m_busy = 1'b0;
  int          m_t    = 0;
  int          m_len  = 0;
  bit          m_bits [16];
  bit          m_done = 1'b0;
  bit          m_ovf  = 1'b0;

  // Observation log
  bit          tx_hist [HIST];
  bit          tx_prev = 1'b1;
  int          falls[$];
  int          dones[$];
  int          ovfs   = 0;
  int          maxc   = 0;
  bit          fullseen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Frame bits for word d: start, data LSB first, parity, stop bits.
  task automatic build(input int unsigned d);
    int db, n, ones;
    db   = cfg_db[sel];
    ones = 0;
    m_bits[0] = 1'b0;
    n = 1;
    for (int i = 0; i < db; i++) begin
      m_bits[n] = ((d >> i) & 1) != 0;
      ones += int'((d >> i) & 1);
      n++;
    end
    if (cfg_par[sel] == 1) begin
      m_bits[n] = (ones % 2) == 0;
      n++;
    end else if (cfg_par[sel] == 2) begin
      m_bits[n] = (ones % 2) == 1;
      n++;
    end
    for (int i = 0; i < cfg_stop[sel]; i++) begin
      m_bits[n] = 1'b1;
      n++;
    end
    m_len = n * CPB;
  endtask

  task automatic model_edge(input bit w, input int unsigned d);
    int unsigned sz;
    bit full_pre, pop_pre, frame_end;
    sz        = mq.size();
    full_pre  = (sz == DEPTH);
    frame_end = m_busy && (m_t == m_len - 1);
    pop_pre   = (sz != 0) && (!m_busy || frame_end);
    m_done    = frame_end;
    if (m_busy && !frame_end) begin
      m_t++;
    end else if (pop_pre) begin
      build(mq.pop_front());
      m_t    = 0;
      m_busy = 1'b1;
    end else begin
      m_busy = 1'b0;
    end
    m_ovf = w && full_pre;
    if (w && !full_pre) mq.push_back(d & ((32'd1 << cfg_db[sel]) - 1));
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_t    = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic compare_all();
    int unsigned sz;
    sz = mq.size();
    chk("tx",     tx_o,    m_busy ? m_bits[m_t / CPB] : 1'b1);
    chk("active", act_o,   m_busy);
    chk("done",   done_o,  m_done);
    chk("ovf",    ovf_o,   m_ovf);
    chk("count",  count_o, sz);
    chk("empty",  empty_o, sz == 0);
    chk("full",   full_o,  sz == DEPTH);
  endtask

  // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
  task automatic step(input bit w, input logic [7:0] d);
    dv  = w;
    din = d;
    @(posedge clk);
    model_edge(w, d);
    #1;
    cyc++;
    if (cyc < HIST) tx_hist[cyc] = tx_o;
    if (tx_prev && !tx_o) falls.push_back(cyc);
    if (done_o) dones.push_back(cyc);
    if (ovf_o) ovfs++;
    if (full_o) fullseen = 1'b1;
    if (int'(count_o) > maxc) maxc = int'(count_o);
    tx_prev = tx_o;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic mark();
    falls.delete();
    dones.delete();
    ovfs     = 0;
    maxc     = 0;
    fullseen = 1'b0;
  endtask

  function automatic bit hist_at(input int idx);
    if (idx >= 0 && idx < HIST) return tx_hist[idx];
    return 1'b1;
  endfunction

  int f0;
  bit exp55 [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  bit exp07 [11] = '{0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    rst = 1'b1;
    sel = 2'd0;
    dv  = 1'b0;
    din = 8'h00;
    #12;
    chk("rst_tx",    tx_o,    1);
    chk("rst_act",   act_o,   0);
    chk("rst_done",  done_o,  0);
    chk("rst_ovf",   ovf_o,   0);
    chk("rst_count", count_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full",  full_o,  0);
    #11;
    rst = 1'b0;

    // Basic 8N1 frame of 0x55
    mark();
    step(1'b1, 8'h55);
    chk("basic_cnt1", count_o, 1);
    step(1'b0, 8'h00);
    chk("basic_latency", tx_o, 0);
    idle(50);
    chk("basic_fall", falls.size() > 0, 1);
    f0 = (falls.size() > 0) ? falls[0] : 0;
    for (int i = 0; i < 10; i++) chk("basic_bit", hist_at(f0 + CPB * i + 1), exp55[i]);
    chk("basic_ndone", dones.size(), 1);
    chk("basic_len", (dones.size() > 0) ? dones[0] - f0 : -1, 40);
    chk("basic_act_end", act_o, 0);

    // Burst of three words, no idle gap between frames
    mark();
    step(1'b1, 8'hA5);
    step(1'b1, 8'h3C);
    step(1'b1, 8'hFF);
    idle(130);
    chk("burst_ndone", dones.size(), 3);
    f0 = (falls.size() > 0) ? falls[0] : 0;
    if (dones.size() == 3) begin
      chk("burst_gap1", dones[1] - dones[0], 40);
      chk("burst_gap2", dones[2] - dones[1], 40);
      chk("burst_total", dones[2] - f0, 120);
    end
    chk("burst_peak", (maxc >= 2) && (maxc <= 3), 1);
    chk("burst_empty", empty_o, 1);

    // Overflow: one word starts a frame, then six writes back-to-back
    mark();
    step(1'b1, 8'h81);
    for (int i = 0; i < 6; i++) step(1'b1, 8'h90 + 8'(i));
    idle(230);
    chk("ovf_fullseen", fullseen, 1);
    chk("ovf_pulses", ovfs, 2);
    chk("ovf_frames", dones.size(), 5);

    // Reset mid-frame with two words still queued
    mark();
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    idle(12);
    chk("mid_act_before", act_o, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_tx",    tx_o,    1);
    chk("mid_act",   act_o,   0);
    chk("mid_count", count_o, 0);
    chk("mid_empty", empty_o, 1);
    model_reset();
    tx_prev = 1'b1;
    #2;
    rst = 1'b0;
    mark();
    idle(60);
    chk("mid_no_frame", falls.size(), 0);
    chk("mid_no_done",  dones.size(), 0);
    step(1'b1, 8'h5A);
    idle(45);
    chk("mid_new_frame", dones.size(), 1);

    // Instance B: 7 data bits, even parity, 2 stop bits
    sel = 2'd1;
    mark();
    step(1'b1, 8'h07);
    idle(50);
    f0 = (falls.size() > 0) ? falls[0] : 0;
    for (int i = 0; i < 11; i++) chk("par_bit", hist_at(f0 + CPB * i + 1), exp07[i]);
    chk("par_len", (dones.size() > 0) ? dones[0] - f0 : -1, 44);

    // Instance C: odd parity
    sel = 2'd2;
    mark();
    step(1'b1, 8'h00);
    idle(45);
    f0 = (falls.size() > 0) ? falls[0] : 0;
    chk("odd_par_00", hist_at(f0 + CPB * 9 + 1), 1);
    mark();
    step(1'b1, 8'h01);
    idle(45);
    f0 = (falls.size() > 0) ? falls[0] : 0;
    chk("odd_par_01", hist_at(f0 + CPB * 9 + 1), 0);

    // Randomised traffic on every instance, checked against the model
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      for (int i = 0; i < 350; i++) step($urandom_range(0, 2) == 0, 8'($urandom));
      idle(260);
      chk("rand_drained", empty_o, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
